// File: rtl/ps2_key_decoder_pkg.sv
// Shared scancode constants, frame geometry and decoder state encoding for the PS/2 front end.
package ps2_key_decoder_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] CAPS_CODE  = 8'h58;

  localparam logic [3:0] FRAME_LAST = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } dec_state_t;

  // Data bits plus parity must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-state bundle presented to the ASCII lookup and display logic; all fields are registered.
interface ps2_key_decoder_if;
  logic [7:0] scancode;
  logic       key_down;
  logic       new_key;
  logic       caps_lock;
  logic [7:0] press_count;
  logic       parity_err;
  logic       overflow;

  modport master (
    output scancode, key_down, new_key, caps_lock, press_count, parity_err, overflow
  );

  modport slave (
    input scancode, key_down, new_key, caps_lock, press_count, parity_err, overflow
  );
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 receiver: 3-flop sync, falling-edge bit capture, frame check, mid-frame timeout and byte FIFO.
// Byte lands in the FIFO at the edge after the stop-bit edge is seen; a push into a full FIFO without a pop is dropped.
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [2:0]       clk_sync;
  logic [2:0]       dat_sync;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [TW-1:0]    idle_cnt;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [7:0]       mem [2**FIFO_AW];

  logic fall, bit_in, frame_end, frame_ok, push, pop, full, empty, push_ok;

  assign fall      = (clk_sync[2:1] == 2'b10);
  assign bit_in    = dat_sync[2];
  assign frame_end = fall && (bit_cnt == FRAME_LAST);
  // shreg[0] is the start bit, [8:1] data LSB first, [9] parity; bit_in is the stop bit.
  assign frame_ok  = !shreg[0] && bit_in && odd_parity_ok(shreg[9:1]);
  assign push      = frame_end && frame_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop      = rx_ready && !empty;
  assign push_ok  = push && (!full || pop);
  assign rx_valid = !empty;
  assign rx_byte  = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= 3'b111;
      dat_sync   <= 3'b111;
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      dat_sync   <= {dat_sync[1:0], ps2_data};
      parity_err <= frame_end && !frame_ok;

      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == FRAME_LAST) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {bit_in, shreg[9:1]};
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == IDLE_LAST) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= shreg[8:1];
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Make/break/extended decoder over the received byte stream; registers update two cycles after the stop-bit edge.
// Consumes one FIFO byte per cycle; dec_hold freezes the decoder in reset and stops popping.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int FIFO_AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_key_decoder_if.master kbd
);

  logic       dec_hold;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_parity_err, rx_overflow;

  dec_state_t state;
  logic [7:0] scancode, press_count;
  logic       key_down, new_key, caps_lock;

  assign dec_hold = reset;

  ps2_rx #(.TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_ready   (!dec_hold),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .parity_err (rx_parity_err),
    .overflow   (rx_overflow)
  );

  always_ff @(posedge clk) begin
    if (dec_hold) begin
      state       <= ST_IDLE;
      scancode    <= '0;
      key_down    <= 1'b0;
      new_key     <= 1'b0;
      caps_lock   <= 1'b0;
      press_count <= '0;
    end else begin
      new_key <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == BREAK_CODE) begin
              state <= ST_BREAK;
            end else if (rx_byte == EXT_CODE) begin
              state <= ST_EXT;
            end else if (!(key_down && rx_byte == scancode)) begin
              // A held key re-sending its make is typematic repeat, not a new press.
              scancode    <= rx_byte;
              key_down    <= 1'b1;
              new_key     <= 1'b1;
              press_count <= press_count + 8'd1;
              if (rx_byte == CAPS_CODE) caps_lock <= !caps_lock;
            end
          end
          ST_BREAK: begin
            if (rx_byte == scancode) key_down <= 1'b0;
            state <= ST_IDLE;
          end
          ST_EXT:       state <= (rx_byte == BREAK_CODE) ? ST_EXT_BREAK : ST_IDLE;
          ST_EXT_BREAK: state <= ST_IDLE;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end

  assign kbd.scancode    = scancode;
  assign kbd.key_down    = key_down;
  assign kbd.new_key     = new_key;
  assign kbd.caps_lock   = caps_lock;
  assign kbd.press_count = press_count;
  assign kbd.parity_err  = rx_parity_err;
  assign kbd.overflow    = rx_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboarded bench: PS/2 frames in, key-state model predicts every fresh make and the settled outputs.
module tb_ps2_key_decoder;
  import ps2_key_decoder_pkg::*;

  localparam int TO   = 300;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_decoder_if kbd();

  ps2_key_decoder #(.TIMEOUT(TO), .FIFO_AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_perr = 0;
  int seen_perr = 0;

  typedef struct {
    logic [7:0] code;
    logic       caps;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  // Reference key state, driven purely by the byte stream.
  logic [7:0] m_code;
  logic       m_down;
  logic       m_caps;
  logic [7:0] m_cnt;
  int         m_mode;  // 0 plain, 1 after F0, 2 after E0, 3 after E0 F0

  logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h58};
  logic [7:0] ovf_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic model_clear();
    m_code = 8'h00; m_down = 1'b0; m_caps = 1'b0; m_cnt = 8'h00; m_mode = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    exp_t e;
    case (m_mode)
      1: begin
        if (b == m_code) m_down = 1'b0;
        m_mode = 0;
      end
      2: m_mode = (b == 8'hF0) ? 3 : 0;
      3: m_mode = 0;
      default: begin
        if (b == 8'hF0) m_mode = 1;
        else if (b == 8'hE0) m_mode = 2;
        else if (!(m_down && b == m_code)) begin
          m_code = b;
          m_down = 1'b1;
          m_cnt  = m_cnt + 8'd1;
          if (b == 8'h58) m_caps = ~m_caps;
          e.code = m_code; e.caps = m_caps; e.cnt = m_cnt;
          exp_q.push_back(e);
        end
      end
    endcase
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits, input logic flip_par);
    logic [10:0] f;
    int h;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      h = HALF + $urandom_range(0, 4);
      ps2_data = f[i];
      repeat (h) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (h) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF + $urandom_range(0, 10)) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_apply(b);
    send_frame(b, 11, 1'b0);
  endtask

  task automatic check_state(input string tag);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, ".scancode"}, kbd.scancode, m_code);
    check({tag, ".key_down"}, kbd.key_down, m_down);
    check({tag, ".caps_lock"}, kbd.caps_lock, m_caps);
    check({tag, ".press_count"}, kbd.press_count, m_cnt);
  endtask

  task automatic do_reset();
    check("pending_before_reset", exp_q.size(), 0);
    @(posedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  // Monitor: every new_key pulse must match the oldest predicted fresh make.
  always @(negedge clk) begin
    if (!reset) begin
      if (kbd.parity_err) seen_perr++;
      if (kbd.new_key) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_new_key: got scancode %0h with nothing predicted", kbd.scancode);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("nk.scancode", kbd.scancode, e.code);
          check("nk.caps_lock", kbd.caps_lock, e.caps);
          check("nk.press_count", kbd.press_count, e.cnt);
          check("nk.key_down", kbd.key_down, 1);
        end
      end
    end
  end

  initial begin
    logic [7:0] k;
    model_clear();
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.scancode", kbd.scancode, 0);
    check("rst.key_down", kbd.key_down, 0);
    check("rst.new_key", kbd.new_key, 0);
    check("rst.caps_lock", kbd.caps_lock, 0);
    check("rst.press_count", kbd.press_count, 0);
    check("rst.parity_err", kbd.parity_err, 0);
    check("rst.overflow", kbd.overflow, 0);

    // Key A make then break.
    send_byte(8'h1C);
    check_state("a_make");
    send_byte(8'hF0); send_byte(8'h1C);
    check_state("a_break");

    // CapsLock toggling across two press/release cycles.
    do_reset();
    send_byte(8'h58); check_state("caps1");
    send_byte(8'hF0); send_byte(8'h58);
    send_byte(8'h58); check_state("caps2");
    send_byte(8'hF0); send_byte(8'h58); check_state("caps3");

    // Typematic repeat.
    do_reset();
    repeat (5) send_byte(8'h1C);
    check_state("repeat");
    send_byte(8'hF0); send_byte(8'h1C);
    check_state("repeat_break");

    // Bad parity, then an abandoned partial frame recovered by timeout.
    do_reset();
    exp_perr++;
    send_frame(8'h1C, 11, 1'b1);
    check_state("bad_parity");
    check("parity_err_pulses", seen_perr, exp_perr);
    send_frame(8'h1C, 6, 1'b0);
    repeat (TO + 50) @(posedge clk);
    send_byte(8'h32);
    check_state("after_timeout");

    // FIFO overflow with the decoder held off.
    do_reset();
    force dut.dec_hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) model_apply(ovf_codes[i]);
      send_frame(ovf_codes[i], 11, 1'b0);
    end
    @(negedge clk);
    check("ovf.set", kbd.overflow, 1);
    check("ovf.held_scancode", kbd.scancode, 0);
    release dut.dec_hold;
    repeat (30) @(posedge clk);
    check_state("ovf_drain");
    check("ovf.sticky", kbd.overflow, 1);
    do_reset();
    @(negedge clk);
    check("ovf.cleared", kbd.overflow, 0);
    check("ovf_rst.scancode", kbd.scancode, 0);
    check("ovf_rst.press_count", kbd.press_count, 0);
    check("ovf_rst.key_down", kbd.key_down, 0);

    // Extended sequences are ignored.
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'h1C);
    check_state("ext");

    // Random key traffic.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      k = pool[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: send_byte(k);
        1: repeat ($urandom_range(2, 3)) send_byte(k);
        2: begin send_byte(8'hF0); send_byte(k); end
        default: begin
          send_byte(8'hE0);
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
          send_byte(k);
        end
      endcase
      if (n % 10 == 9) check_state("rand");
    end

    repeat (20) @(posedge clk);
    check("final_pending", exp_q.size(), 0);
    check("final_parity_err_pulses", seen_perr, exp_perr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
